// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} piso_state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Upstream word handshake plus serial output bundle of the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sof;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, sof, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, sof, busy
  );

endinterface

// File: rtl/bit_counter.sv
// Up-counter with synchronous clear and enable that saturates at TERMINAL.
module bit_counter #(
  parameter int CW       = 2,
  parameter int TERMINAL = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam logic [CW-1:0] TERM = CW'(TERMINAL);

  logic [CW-1:0] count;

  // Clear wins over enable; holding at TERM keeps the count from wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + CW'(1);
    end
  end

  assign done = (count == TERM);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a word on valid/ready and emits it one bit per clock.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input logic              clk,
  input logic              rst,
  piso_serializer_if.slave bus
);

  piso_state_t      state;
  logic [WIDTH-1:0] sreg;
  logic             accept;
  logic             bit_done;
  logic             gap_done;

  // A new word can follow the last bit directly only when no idle gap is requested.
  assign bus.din_ready = (state == IDLE) ||
                         ((state == SHIFT) && (GAP == 0) && bit_done);
  assign accept = bus.din_valid && bus.din_ready;

  bit_counter #(
    .CW       (cnt_width(WIDTH)),
    .TERMINAL (WIDTH - 1)
  ) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (state == SHIFT),
    .done  (bit_done)
  );

  bit_counter #(
    .CW       (cnt_width(GAP + 1)),
    .TERMINAL ((GAP > 0) ? GAP - 1 : 0)
  ) u_gap_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (state != piso_pkg::GAP),
    .en    (state == piso_pkg::GAP),
    .done  (gap_done)
  );

  // The first bit is registered on accept, so sreg only holds the bits still to be sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sreg           <= '0;
      bus.sout       <= 1'b0;
      bus.sout_valid <= 1'b0;
      bus.sof        <= 1'b0;
      bus.busy       <= 1'b0;
    end else if (accept) begin
      state          <= SHIFT;
      sreg           <= (MSB_FIRST != 0) ? (bus.din << 1) : (bus.din >> 1);
      bus.sout       <= (MSB_FIRST != 0) ? bus.din[WIDTH-1] : bus.din[0];
      bus.sout_valid <= 1'b1;
      bus.sof        <= 1'b1;
      bus.busy       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        SHIFT: begin
          if (!bit_done) begin
            sreg     <= (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
            bus.sout <= (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
            bus.sof  <= 1'b0;
          end else begin
            state          <= (GAP > 0) ? piso_pkg::GAP : IDLE;
            bus.sout       <= 1'b0;
            bus.sout_valid <= 1'b0;
            bus.sof        <= 1'b0;
            bus.busy       <= (GAP > 0);
          end
        end
        piso_pkg::GAP: begin
          if (gap_done) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          bus.sout       <= 1'b0;
          bus.sout_valid <= 1'b0;
          bus.sof        <= 1'b0;
          bus.busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
